// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types for stream_fifo and its RAM.
// Level/occupancy signals are SIZE+1 bits wide so that DEPTH itself is representable.
package fifo_pkg;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Total capacity for a given log2 size.
    function automatic int unsigned fifo_depth(input int unsigned size);
        return 32'd1 << size;
    endfunction

    // Width of level/threshold signals: must hold 0..DEPTH inclusive.
    function automatic int unsigned level_width(input int unsigned size);
        return size + 1;
    endfunction

    // Source of the word presented on the output.
    typedef enum logic {
        SelRam = 1'b0,
        SelByp = 1'b1
    } out_sel_e;

endpackage

// File: rtl/stream_fifo_if.sv
// stream_fifo_if: valid/ready stream with data; master drives data/valid, slave drives ready.
interface stream_fifo_if #(
    parameter int unsigned WIDTH = 48
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: WIDTH x 2^SIZE simple dual-port RAM, one write and one registered read per cycle.
module fifo_ram #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned SIZE  = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [SIZE-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [SIZE-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    import fifo_pkg::*;

    localparam int unsigned ENTRIES = fifo_depth(SIZE);

    logic [WIDTH-1:0] mem [ENTRIES];

    // Write port and registered read port; read data holds when rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: single-clock first-word-fall-through FIFO with valid/ready on both sides,
// occupancy level, programmable almost-full/almost-empty and synchronous clear.
// Optional macro FIFO_HWM_EN adds a high-water-mark output (hwm) and its clear (hwm_clr).
// The head word lives either in the bypass register (written straight from the input
// when the FIFO is empty) or in the RAM's registered read data; out_sel picks between them.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned SIZE  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    stream_fifo_if.slave    push,
    stream_fifo_if.master   pop,
    output logic [SIZE:0]   level,
    input  logic [SIZE:0]   afull_thr,
    input  logic [SIZE:0]   aempty_thr,
    output logic            almost_full,
`ifdef FIFO_HWM_EN
    input  logic            hwm_clr,
    output logic [SIZE:0]   hwm,
`endif
    output logic            almost_empty
);

    localparam int unsigned DEPTH = fifo_depth(SIZE);
    localparam int unsigned LW    = level_width(SIZE);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [LW-1:0]    level_q, level_d;
    logic [SIZE-1:0]  wr_ptr_q, wr_ptr_d;
    logic [SIZE-1:0]  rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    out_sel_e         sel_q, sel_d;
    logic [WIDTH-1:0] byp_q, byp_d;

    logic             in_ready;
    logic             do_wr;
    logic             do_rd;
    logic             slot_free;
    logic [LW-1:0]    ram_cnt;
    logic             ram_we;
    logic             ram_re;
    logic [WIDTH-1:0] ram_rdata;

    // in_ready depends only on registered level and clear, never on out_ready.
    assign in_ready   = (level_q != DEPTH_L) && !clear;
    assign push.ready = in_ready;
    assign do_wr      = push.valid && in_ready;
    assign do_rd      = out_valid_q && pop.ready;
    // Output slot is available to be (re)filled this edge.
    assign slot_free  = !out_valid_q || do_rd;
    // Words held in RAM, excluding the one in the output slot.
    assign ram_cnt    = level_q - LW'(out_valid_q);

    assign pop.valid    = out_valid_q;
    assign pop.data     = (sel_q == SelByp) ? byp_q : ram_rdata;
    assign level        = level_q;
    assign almost_full  = (level_q >= afull_thr);
    assign almost_empty = (level_q <= aempty_thr);

    // Next-state: refill the output slot from RAM first, else bypass a fresh write.
    always_comb begin
        level_d     = level_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        sel_d       = sel_q;
        byp_d       = byp_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        if (slot_free && (ram_cnt != '0)) begin
            ram_re      = 1'b1;
            rd_ptr_d    = rd_ptr_q + SIZE'(1);
            out_valid_d = 1'b1;
            sel_d       = SelRam;
            if (do_wr) begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + SIZE'(1);
            end
        end else if (slot_free && do_wr) begin
            byp_d       = push.data;
            sel_d       = SelByp;
            out_valid_d = 1'b1;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end else if (do_wr) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + SIZE'(1);
        end

        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Nothing reaches the RAM while the state is being wiped.
        if (reset || clear) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // State registers; reset and clear both discard all contents.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            sel_q       <= SelByp;
            byp_q       <= '0;
        end else begin
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            byp_q       <= byp_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (push.data),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

`ifdef FIFO_HWM_EN
    logic [LW-1:0] hwm_q;

    // High-water mark tracks registered level one edge later; hwm_clr reloads it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hwm_q <= '0;
        end else if (hwm_clr) begin
            hwm_q <= level_q;
        end else if (level_q > hwm_q) begin
            hwm_q <= level_q;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed vector table plus a queue model for multi-cycle sequences.
module tb_stream_fifo;

    localparam int unsigned W = 48;
    localparam int unsigned S = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic [S:0]   level;
    logic [S:0]   afull_thr;
    logic [S:0]   aempty_thr;
    logic         almost_full;
    logic         almost_empty;
    logic         hwm_clr;
    logic [S:0]   hwm;

    stream_fifo_if #(.WIDTH(W)) push_if ();
    stream_fifo_if #(.WIDTH(W)) pop_if ();

    stream_fifo #(
        .WIDTH (W),
        .SIZE  (S)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .push         (push_if),
        .pop          (pop_if),
        .level        (level),
        .afull_thr    (afull_thr),
        .aempty_thr   (aempty_thr),
        .almost_full  (almost_full),
`ifdef FIFO_HWM_EN
        .hwm_clr      (hwm_clr),
        .hwm          (hwm),
`endif
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic [S:0]   aft;
        logic [S:0]   aet;
        logic [S:0]   lvl;
        logic         ov;
        logic [W-1:0] od;
        logic         ir;
        logic         af;
        logic         ae;
    } vec_t;

    vec_t         vtab[$];
    logic [W-1:0] exp_q[$];
    int           total_cnt = 0;
    int           pass_cnt  = 0;

    function automatic vec_t mk(input logic iv, input logic [W-1:0] id, input logic ordy,
                                input logic [S:0] aft, input logic [S:0] aet,
                                input logic [S:0] lvl, input logic ov, input logic [W-1:0] od,
                                input logic ir, input logic af, input logic ae);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.aft = aft; v.aet = aet;
        v.lvl = lvl; v.ov = ov; v.od = od; v.ir = ir; v.af = af; v.ae = ae;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock with the queue model: check head/ready before the edge, level after it.
    task automatic cycle_model(input logic iv, input logic [W-1:0] id, input logic ordy);
        logic exp_ir;
        exp_ir = (exp_q.size() != 8);
        chk("m_in_ready", {63'd0, push_if.ready}, {63'd0, exp_ir});
        chk("m_out_valid", {63'd0, pop_if.valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("m_out_data", {16'd0, pop_if.data}, {16'd0, exp_q[0]});
        end
        push_if.valid = iv;
        push_if.data  = id;
        pop_if.ready  = ordy;
        @(posedge clk);
        #1;
        if (ordy && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        if (iv && exp_ir) begin
            exp_q.push_back(id);
        end
        chk("m_level", {60'd0, level}, 64'(exp_q.size()));
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        hwm_clr = 1'b0;
        push_if.valid = 1'b0;
        push_if.data  = '0;
        pop_if.ready  = 1'b0;
        afull_thr  = 4'd15;
        aempty_thr = 4'd0;

        // Table: fill 1..8, overflow attempt, drain, bypass cases, threshold boundaries.
        for (int k = 1; k <= 8; k++) begin
            vtab.push_back(mk(1'b1, W'(k), 1'b0, 4'd6, 4'd2, 4'(k), 1'b1, W'(1),
                              k != 8, k >= 6, k <= 2));
        end
        vtab.push_back(mk(1'b1, W'(9), 1'b0, 4'd6, 4'd2, 4'd8, 1'b1, W'(1), 1'b0, 1'b1, 1'b0));
        for (int j = 1; j <= 8; j++) begin
            vtab.push_back(mk(1'b0, '0, 1'b1, 4'd6, 4'd2, 4'(8 - j), j != 8, W'(j + 1),
                              1'b1, (8 - j) >= 6, (8 - j) <= 2));
        end
        vtab.push_back(mk(1'b1, 48'hABC, 1'b0, 4'd6, 4'd2, 4'd1, 1'b1, 48'hABC, 1'b1, 1'b0, 1'b1));
        vtab.push_back(mk(1'b0, '0, 1'b1, 4'd6, 4'd2, 4'd0, 1'b0, '0, 1'b1, 1'b0, 1'b1));
        vtab.push_back(mk(1'b1, 48'h11, 1'b0, 4'd6, 4'd2, 4'd1, 1'b1, 48'h11, 1'b1, 1'b0, 1'b1));
        vtab.push_back(mk(1'b1, 48'h22, 1'b1, 4'd6, 4'd2, 4'd1, 1'b1, 48'h22, 1'b1, 1'b0, 1'b1));
        vtab.push_back(mk(1'b0, '0, 1'b1, 4'd6, 4'd2, 4'd0, 1'b0, '0, 1'b1, 1'b0, 1'b1));
        vtab.push_back(mk(1'b0, '0, 1'b0, 4'd0, 4'd8, 4'd0, 1'b0, '0, 1'b1, 1'b1, 1'b1));
        vtab.push_back(mk(1'b1, 48'h33, 1'b0, 4'd1, 4'd0, 4'd1, 1'b1, 48'h33, 1'b1, 1'b1, 1'b0));
        vtab.push_back(mk(1'b0, '0, 1'b1, 4'd15, 4'd15, 4'd0, 1'b0, '0, 1'b1, 1'b0, 1'b1));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_level", {60'd0, level}, 64'd0);
        chk("rst_out_valid", {63'd0, pop_if.valid}, 64'd0);
        chk("rst_out_data", {16'd0, pop_if.data}, 64'd0);
        chk("rst_in_ready", {63'd0, push_if.ready}, 64'd1);
        chk("rst_almost_empty", {63'd0, almost_empty}, 64'd1);
        chk("rst_almost_full", {63'd0, almost_full}, 64'd0);

        // Apply the vector table.
        for (int i = 0; i < vtab.size(); i++) begin
            push_if.valid = vtab[i].iv;
            push_if.data  = vtab[i].id;
            pop_if.ready  = vtab[i].ordy;
            afull_thr     = vtab[i].aft;
            aempty_thr    = vtab[i].aet;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", i), {60'd0, level}, {60'd0, vtab[i].lvl});
            chk($sformatf("v%0d_out_valid", i), {63'd0, pop_if.valid}, {63'd0, vtab[i].ov});
            if (vtab[i].ov) begin
                chk($sformatf("v%0d_out_data", i), {16'd0, pop_if.data}, {16'd0, vtab[i].od});
            end
            chk($sformatf("v%0d_in_ready", i), {63'd0, push_if.ready}, {63'd0, vtab[i].ir});
            chk($sformatf("v%0d_almost_full", i), {63'd0, almost_full}, {63'd0, vtab[i].af});
            chk($sformatf("v%0d_almost_empty", i), {63'd0, almost_empty}, {63'd0, vtab[i].ae});
        end

        // Full FIFO streaming with read and write every cycle; pointers wrap repeatedly.
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            cycle_model(1'b1, W'(32'h100 + k), 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            cycle_model(1'b1, W'(32'h200 + k), 1'b1);
        end
        for (int k = 0; k < 10; k++) begin
            cycle_model(1'b0, '0, 1'b1);
        end

        // Clear at level 5 with a write offered during clear.
        for (int k = 0; k < 5; k++) begin
            cycle_model(1'b1, W'(32'h300 + k), 1'b0);
        end
        push_if.valid = 1'b1;
        push_if.data  = 48'hDEAD;
        pop_if.ready  = 1'b0;
        clear = 1'b1;
        #1;
        chk("clr_in_ready_during", {63'd0, push_if.ready}, 64'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        push_if.valid = 1'b0;
        #1;
        chk("clr_level", {60'd0, level}, 64'd0);
        chk("clr_out_valid", {63'd0, pop_if.valid}, 64'd0);
        chk("clr_out_data", {16'd0, pop_if.data}, 64'd0);
        chk("clr_in_ready", {63'd0, push_if.ready}, 64'd1);
        exp_q.delete();
        cycle_model(1'b1, 48'h77, 1'b0);
        cycle_model(1'b0, '0, 1'b1);
        cycle_model(1'b0, '0, 1'b0);

`ifdef FIFO_HWM_EN
        // High-water mark: fill to 7, drain to 2, clear mark, write one more.
        for (int k = 0; k < 7; k++) begin
            cycle_model(1'b1, W'(32'h400 + k), 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            cycle_model(1'b0, '0, 1'b1);
        end
        chk("hwm_peak", {60'd0, hwm}, 64'd7);
        hwm_clr = 1'b1;
        cycle_model(1'b0, '0, 1'b0);
        hwm_clr = 1'b0;
        chk("hwm_cleared", {60'd0, hwm}, 64'd2);
        cycle_model(1'b1, 48'h500, 1'b0);
        cycle_model(1'b0, '0, 1'b0);
        chk("hwm_regrow", {60'd0, hwm}, 64'd3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Synchronous single-clock FIFO with valid/ready handshakes on both sides and first-word-fall-through output. Successor to the plain wr/rd FIFO, adding:
- occupancy count
- runtime-programmable almost-full / almost-empty thresholds
- synchronous flush

Sits between audio sample producers (I2S/DSP paths, default 48-bit stereo word) and bus-side consumers. Also usable as a generic elastic buffer.

Parameters:
WIDTH, 48, data word width in bits.
SIZE, 8, log2 of capacity; DEPTH = 2^SIZE total entries, including the output register.

Ports:
clk  in  1  clock.
reset  in  1  reset, synchronous, active-high.
clear  in  1  synchronous flush; empties the FIFO without reset.
in_data  in  WIDTH  write data.
in_valid  in  1  write request.
in_ready  out  1  FIFO can accept; transfer on in_valid && in_ready.
out_data  out  WIDTH  head-of-FIFO word; valid while out_valid.
out_valid  out  1  head word present.
out_ready  in  1  consumer accepts; transfer on out_valid && out_ready.
level  out  SIZE+1  current occupancy, 0..DEPTH.
afull_thr  in  SIZE+1  almost-full threshold.
aempty_thr  in  SIZE+1  almost-empty threshold.
almost_full  out  1  level >= afull_thr.
almost_empty  out  1  level <= aempty_thr.

Behaviour:
- Reset, synchronous and dominant:
  - level=0, out_valid=0, out_data=0, pointers=0.
  - in_ready=1 on the first cycle after reset deasserts.
- Clear, evaluated when reset is low: same effect as reset on pointers, level, out_valid and out_data. While clear=1, in_ready=0 and any write is discarded.
- in_ready = (level != DEPTH) && !clear. It is a function of registered state only; no combinational path from out_ready or in_valid.
- out_valid and out_data are registered outputs. out_data holds its value while out_valid && !out_ready.
- Latency: a word accepted at edge E is visible on out_valid/out_data after edge E when the FIFO was empty, via bypass into the output register. Minimum write-to-read latency is 1 cycle.
- Ordering: strict FIFO order; no word is lost or duplicated.
- level update per edge:
  - +1 on write transfer only.
  - −1 on read transfer only.
  - unchanged when both occur.
- Full (level==DEPTH) with a simultaneous read:
  - The read completes.
  - in_ready stays 0 that cycle, since it is derived from the registered level.
  - in_ready rises the next cycle.
- Empty with a simultaneous write: the word enters the output register; out_valid=1 next cycle; level=1.
- Pointer wrap: read/write pointers are SIZE-bit and wrap modulo the RAM depth. Occupancy is tracked by level, not by pointer MSB comparison.
- almost_full and almost_empty:
  - Combinational compares of the registered level against the threshold inputs.
  - Threshold changes take effect in the same cycle.
  - afull_thr=0 → almost_full is always 1.
  - aempty_thr ≥ DEPTH → almost_empty is always 1.
- Reset or clear asserted mid-burst: all contents are discarded at that edge. Transfers offered in that cycle are not performed.
- RAM: simple dual-port, registered read, one read and one write per cycle. The output register is refilled from RAM whenever it is empty or being consumed and RAM holds data.

Optional Feature:
Macro FIFO_HWM_EN.
- Defined:
  - Adds output hwm (SIZE+1 bits): the maximum level since the last reset, clear or hwm_clr.
  - Adds input hwm_clr (1 bit): a synchronous pulse that loads hwm with the current level.
  - hwm updates one edge after level, i.e. it is registered from level.
- Not defined: both ports and the tracking logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg:
  - function clog2
  - localparam helper for DEPTH = 1 << SIZE
  - level-width constant convention (SIZE+1)
- One sub-module: fifo_ram, a parametrised WIDTH × 2^SIZE simple dual-port RAM with registered read.
- Pointer, level, bypass and output-register control stay in stream_fifo.

Test Plan:
1. Reset, then idle → level=0, out_valid=0, in_ready=1, almost_empty=1 (aempty_thr=0), almost_full=0 (afull_thr=200).
2. SIZE=3: write 0x1..0x8 with out_ready=0 → level=8, in_ready=0, almost_full=1 (afull_thr=6). Then read 8 → data 0x1..0x8 in order, level returns to 0.
3. Empty FIFO: single write 0xABC at edge E → out_valid=1 and out_data=0xABC after E. Read next cycle → out_valid=0, level=0.
4. Full FIFO with out_ready=1 and in_valid=1 for 20 cycles → one read per cycle. in_ready toggles per the registered-level rule; the output sequence is gapless and ordered; pointers wrap with no corruption.
5. Level 5 mid-stream, pulse clear → next cycle level=0, out_valid=0, in_ready=1. A write offered during clear is absent from the output.
6. FIFO_HWM_EN: fill to level 7, drain to 2 → hwm=7. Pulse hwm_clr → hwm=2. Write 1 → hwm=3.
